// File: rtl/phy_tx_ser_pkg.sv
// rtl/phy_tx_ser_pkg.sv - shared symbols, state encoding and lane helper for the PHY transmit serializer
//
// Purpose: one place for the line symbols and the framing state encoding, so the
// transmit and receive ends agree on what COM and IDL look like on the wire.
// Contents:
//   tx_state_e   framing state (SYNC while sending the COM preamble, ACTIVE afterwards)
//   COM_SYM_DEF  default comma/sync symbol
//   IDL_SYM_DEF  default idle symbol for lanes without valid data
//   LANES        lanes per frame
//   lane_symbol  picks the lane byte or the idle symbol from the lane valid bit

package phy_tx_ser_pkg;

  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } tx_state_e;

  localparam logic [7:0] COM_SYM_DEF = 8'hBC;
  localparam logic [7:0] IDL_SYM_DEF = 8'h7C;
  localparam int         LANES       = 4;

  function automatic logic [7:0] lane_symbol(input logic       vld,
                                             input logic [7:0] data,
                                             input logic [7:0] idl);
    return vld ? data : idl;
  endfunction

endpackage

// File: rtl/phy_tx_piso.sv
// rtl/phy_tx_piso.sv - 8-bit parallel-in serial-out register with bit counter
//
// Purpose: holds the symbol being transmitted and shifts it out MSB-first.
// Ports:
//   clk32f  in   serial-rate clock
//   reset   in   asynchronous, active-high reset
//   load    in   load din on this edge (bit counter restarts at 0)
//   din     in   [7:0] next symbol
//   dout    out  current bit on the line (sreg MSB)
//   last    out  high while the final bit of the symbol is on the line (bit_cnt==7)

module phy_tx_piso (
  input  logic       clk32f,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] din,
  output logic       dout,
  output logic       last
);

  logic [7:0] sreg;
  logic [2:0] bit_cnt;

  // bit_cnt resets to 7 so the very first edge after reset is a load edge.
  always_ff @(posedge clk32f or posedge reset) begin
    if (reset) begin
      sreg    <= 8'h00;
      bit_cnt <= 3'd7;
    end else if (load) begin
      sreg    <= din;
      bit_cnt <= 3'd0;
    end else if (bit_cnt != 3'd7) begin
      sreg    <= {sreg[6:0], 1'b0};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  assign dout = sreg[7];
  assign last = (bit_cnt == 3'd7);

endmodule

// File: rtl/phy_tx_ser.sv
// rtl/phy_tx_ser.sv - PHY transmit serializer: COM preamble, 4-lane frame buffer, lane mux
//
// Purpose: after reset sends COM_COUNT COM symbols so the far-end receiver can
// lock, then repeatedly sends a latched 4-lane frame bit-serially, lane 0 first,
// each byte MSB-first, with IDL in any lane whose valid bit was clear.
// Ports:
//   clk32f    in   serial-rate clock, the only clock
//   reset     in   asynchronous, active-high reset
//   in0..in3  in   [7:0] lane bytes, taken on the edge where in_ready=1
//   valid_in  in   [3:0] per-lane valid, bit k qualifies in<k>
//   in_ready  out  combinational; high in the cycle whose rising edge captures a frame
//   out       out  serial bit stream
//   active    out  high once the framing state is ACTIVE

module phy_tx_ser
  import phy_tx_ser_pkg::*;
#(
  parameter int         COM_COUNT = 4,
  parameter logic [7:0] COM_SYM   = COM_SYM_DEF,
  parameter logic [7:0] IDL_SYM   = IDL_SYM_DEF
) (
  input  logic       clk32f,
  input  logic       reset,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [3:0] valid_in,
  output logic       in_ready,
  output logic       out,
  output logic       active
);

  // com_cnt must be able to hold COM_COUNT, where it parks once ACTIVE.
  localparam int          CW       = $clog2(COM_COUNT + 1);
  localparam logic [CW-1:0] COM_LAST = CW'(COM_COUNT - 1);

  tx_state_e              state_q, state_d;
  logic [CW-1:0]          com_cnt_q, com_cnt_d;
  logic [1:0]             lane_cnt_q, lane_cnt_d;
  logic [LANES-1:0][7:0]  buf_data_q;
  logic [LANES-1:0]       buf_valid_q;
  logic [7:0]             sym_d;
  logic                   last;

  phy_tx_piso u_piso (
    .clk32f (clk32f),
    .reset  (reset),
    .load   (last),
    .din    (sym_d),
    .dout   (out),
    .last   (last)
  );

  always_ff @(posedge clk32f or posedge reset) begin
    if (reset) begin
      state_q    <= ST_SYNC;
      com_cnt_q  <= '0;
      lane_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      com_cnt_q  <= com_cnt_d;
      lane_cnt_q <= lane_cnt_d;
    end
  end

  // Frame buffer. The lane-3 symbol loaded on the capture edge reads the old
  // contents, because sym_d is formed from the registered buffer.
  always_ff @(posedge clk32f or posedge reset) begin
    if (reset) begin
      buf_data_q  <= '0;
      buf_valid_q <= '0;
    end else if (in_ready) begin
      buf_data_q  <= {in3, in2, in1, in0};
      buf_valid_q <= valid_in;
    end
  end

  always_comb begin
    state_d    = state_q;
    com_cnt_d  = com_cnt_q;
    lane_cnt_d = lane_cnt_q;
    sym_d      = COM_SYM;
    in_ready   = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (last) begin
          sym_d     = COM_SYM;
          com_cnt_d = com_cnt_q + CW'(1);
          // The last COM edge also captures the first frame, so lane 0 of
          // that frame follows the preamble without a gap.
          if (com_cnt_q == COM_LAST) begin
            in_ready   = 1'b1;
            state_d    = ST_ACTIVE;
            lane_cnt_d = 2'd0;
          end
        end
      end
      ST_ACTIVE: begin
        if (last) begin
          sym_d      = lane_symbol(buf_valid_q[lane_cnt_q], buf_data_q[lane_cnt_q], IDL_SYM);
          lane_cnt_d = lane_cnt_q + 2'd1;
          if (lane_cnt_q == 2'd3) begin
            in_ready = 1'b1;
          end
        end
      end
    endcase
  end

  assign active = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_phy_tx_ser.sv
// tb/tb_phy_tx_ser.sv - directed self-checking bench for phy_tx_ser

module tb_phy_tx_ser;

  logic       clk32f;
  logic       reset;
  logic [7:0] in0, in1, in2, in3;
  logic [3:0] valid_in;
  logic       in_ready;
  logic       out;
  logic       active;

  int n_cmp;
  int n_err;

  logic [7:0]  exp_sym   [0:31];
  logic [31:0] frm_data  [0:7];
  logic [3:0]  frm_valid [0:7];
  int          n_frames;

  phy_tx_ser dut (
    .clk32f   (clk32f),
    .reset    (reset),
    .in0      (in0),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .valid_in (valid_in),
    .in_ready (in_ready),
    .out      (out),
    .active   (active)
  );

  initial begin
    clk32f = 1'b0;
    forever #5 clk32f = ~clk32f;
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_junk();
    in0 = 8'hE7; in1 = 8'hE7; in2 = 8'hE7; in3 = 8'hE7;
    valid_in = 4'hF;
  endtask

  // Runs n_edges clock edges from a reset release. After edge n the line shows
  // symbol (n-1)/8; frames are presented only on the cycles the edge schedule
  // says will capture (edge 25, then every 32).
  task automatic run_stream(input int n_edges);
    logic [7:0] acc;
    logic       exp_rdy;
    int         k;
    k   = 0;
    acc = 8'h00;
    drive_junk();
    for (int n = 1; n <= n_edges; n++) begin
      @(posedge clk32f);
      #1;
      acc = {acc[6:0], out};
      if (((n - 1) % 8) == 7)
        expect_eq($sformatf("sym%0d", (n - 1) / 8), {24'h0, acc}, {24'h0, exp_sym[(n - 1) / 8]});
      expect_eq($sformatf("active@%0d", n), {31'h0, active}, {31'h0, (n >= 25)});
      exp_rdy = ((n + 1) >= 25) && (((n + 1 - 25) % 32) == 0);
      expect_eq($sformatf("in_ready@%0d", n), {31'h0, in_ready}, {31'h0, exp_rdy});
      if (exp_rdy && k < n_frames) begin
        {in0, in1, in2, in3} = frm_data[k];
        valid_in = frm_valid[k];
        k++;
      end else begin
        drive_junk();
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    drive_junk();
    repeat (3) @(posedge clk32f);
    #1;
    expect_eq("rst_out", {31'h0, out}, 32'h0);
    expect_eq("rst_active", {31'h0, active}, 32'h0);
    expect_eq("rst_in_ready", {31'h0, in_ready}, 32'h0);

    // Phase 1: preamble, idle frame, full frame, partial valid, back-to-back frames.
    exp_sym[0]  = 8'hBC; exp_sym[1]  = 8'hBC; exp_sym[2]  = 8'hBC; exp_sym[3]  = 8'hBC;
    exp_sym[4]  = 8'h7C; exp_sym[5]  = 8'h7C; exp_sym[6]  = 8'h7C; exp_sym[7]  = 8'h7C;
    exp_sym[8]  = 8'h01; exp_sym[9]  = 8'h02; exp_sym[10] = 8'h03; exp_sym[11] = 8'h04;
    exp_sym[12] = 8'hFF; exp_sym[13] = 8'h7C; exp_sym[14] = 8'hDD; exp_sym[15] = 8'h7C;
    exp_sym[16] = 8'hAA; exp_sym[17] = 8'hAB; exp_sym[18] = 8'hAC; exp_sym[19] = 8'hAD;
    exp_sym[20] = 8'h55; exp_sym[21] = 8'h56; exp_sym[22] = 8'h57; exp_sym[23] = 8'h58;
    exp_sym[24] = 8'h12;
    frm_data[0] = 32'h11223344; frm_valid[0] = 4'b0000;
    frm_data[1] = 32'h01020304; frm_valid[1] = 4'b1111;
    frm_data[2] = 32'hFFEEDDCC; frm_valid[2] = 4'b0101;
    frm_data[3] = 32'hAAABACAD; frm_valid[3] = 4'b1111;
    frm_data[4] = 32'h55565758; frm_valid[4] = 4'b1111;
    frm_data[5] = 32'h123C5678; frm_valid[5] = 4'b1111;
    n_frames = 6;
    reset = 1'b0;
    run_stream(205);

    // Line is now on bit 3 of 0x3C (a 1); reset must clear it between edges.
    expect_eq("pre_rst_out", {31'h0, out}, 32'h1);
    #3;
    reset = 1'b1;
    #1;
    expect_eq("mid_rst_out", {31'h0, out}, 32'h0);
    expect_eq("mid_rst_active", {31'h0, active}, 32'h0);
    expect_eq("mid_rst_in_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk32f);
    #1;

    // Phase 2: preamble restarts from scratch, then idle frames.
    for (int i = 0; i < 4; i++) exp_sym[i] = 8'hBC;
    for (int i = 4; i < 12; i++) exp_sym[i] = 8'h7C;
    frm_data[0] = 32'h99887766; frm_valid[0] = 4'b0000;
    frm_data[1] = 32'h13579BDF; frm_valid[1] = 4'b0000;
    n_frames = 2;
    reset = 1'b0;
    run_stream(96);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
